// File: rtl/clock_display_scan.sv
// clock_display_scan: snapshots a packed {hour,min,sec} binary time word,
// converts each field to two BCD digits with a serial shift-add-3 engine,
// and scans the result onto a 6-digit multiplexed 7-segment display.
module clock_display_scan #(
  parameter int SCAN_DIV   = 1000,
  parameter bit SEG_ACT_LO = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [17:0] data,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [23:0] bcd_out,
  output logic [5:0]  digit_sel,
  output logic [7:0]  seg
);
  localparam int PW = $clog2(SCAN_DIV);

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state_reg, state_next;
  logic [17:0] shadow_reg;
  logic        pending_reg;
  logic [1:0]  field_reg;
  logic [2:0]  step_reg;
  logic [13:0] dab_reg;
  logic [7:0]  sec_bcd_reg, min_bcd_reg;
  logic        busy_reg, done_reg, valid_reg;
  logic [23:0] bcd_reg;

  logic [5:0]  field_bits;
  logic [13:0] dab_in, dab_adj, dab_next;
  logic        start, commit;

  logic [PW-1:0] presc_reg;
  logic [2:0]    idx_reg;
  logic [5:0]    digit_sel_reg;
  logic [7:0]    seg_reg;
  logic [3:0]    nib;
  logic [7:0]    seg_code;
  logic [5:0]    onehot;

  // One shift-add-3 step; the first step of each field loads the raw binary
  always_comb begin
    field_bits = shadow_reg[5:0];
    case (field_reg)
      2'd1:    field_bits = shadow_reg[11:6];
      2'd2:    field_bits = shadow_reg[17:12];
      default: field_bits = shadow_reg[5:0];
    endcase
    dab_in = (step_reg == 3'd0) ? {8'd0, field_bits} : dab_reg;
    dab_adj = dab_in;
    if (dab_in[9:6] >= 4'd5)   dab_adj[9:6]   = dab_in[9:6] + 4'd3;
    if (dab_in[13:10] >= 4'd5) dab_adj[13:10] = dab_in[13:10] + 4'd3;
    dab_next = dab_adj << 1;
  end

  // Next-state logic: commit on the 18th step, restart if a load is queued
  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (load) begin
          start      = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        if (field_reg == 2'd2 && step_reg == 3'd5) begin
          commit = 1'b1;
          if (pending_reg || load) start = 1'b1;
          else                     state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Conversion datapath, pending flag and atomic commit of all six digits
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shadow_reg  <= '0;
      pending_reg <= 1'b0;
      field_reg   <= '0;
      step_reg    <= '0;
      dab_reg     <= '0;
      sec_bcd_reg <= '0;
      min_bcd_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      bcd_reg     <= '0;
    end else begin
      done_reg <= commit;
      if (start) begin
        shadow_reg  <= data;
        field_reg   <= 2'd0;
        step_reg    <= 3'd0;
        busy_reg    <= 1'b1;
        pending_reg <= 1'b0;
      end else if (state_reg == CONV) begin
        dab_reg <= dab_next;
        if (load) pending_reg <= 1'b1;
        if (step_reg == 3'd5) begin
          step_reg  <= 3'd0;
          field_reg <= field_reg + 2'd1;
          if (field_reg == 2'd0) sec_bcd_reg <= dab_next[13:6];
          if (field_reg == 2'd1) min_bcd_reg <= dab_next[13:6];
        end else begin
          step_reg <= step_reg + 3'd1;
        end
      end
      if (commit) begin
        bcd_reg[23:16] <= (shadow_reg[17:12] <= 6'd23) ? dab_next[13:6] : 8'hFF;
        bcd_reg[15:8]  <= (shadow_reg[11:6]  <= 6'd59) ? min_bcd_reg    : 8'hFF;
        bcd_reg[7:0]   <= (shadow_reg[5:0]   <= 6'd59) ? sec_bcd_reg    : 8'hFF;
        valid_reg      <= 1'b1;
        if (!start) busy_reg <= 1'b0;
      end
    end
  end

  // Free-running prescaler and digit index
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_reg <= '0;
      idx_reg   <= '0;
    end else if (presc_reg == PW'(SCAN_DIV - 1)) begin
      presc_reg <= '0;
      idx_reg   <= (idx_reg == 3'd5) ? 3'd0 : idx_reg + 3'd1;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  // Segment decode of the nibble for the current digit, dp on separators
  always_comb begin
    nib    = bcd_reg[{idx_reg, 2'b00} +: 4];
    onehot = 6'b000001 << idx_reg;
    case (nib)
      4'h0:    seg_code = 8'h3F;
      4'h1:    seg_code = 8'h06;
      4'h2:    seg_code = 8'h5B;
      4'h3:    seg_code = 8'h4F;
      4'h4:    seg_code = 8'h66;
      4'h5:    seg_code = 8'h6D;
      4'h6:    seg_code = 8'h7D;
      4'h7:    seg_code = 8'h07;
      4'h8:    seg_code = 8'h7F;
      4'h9:    seg_code = 8'h6F;
      4'hF:    seg_code = 8'h40;
      default: seg_code = 8'h00;
    endcase
    if (idx_reg == 3'd2 || idx_reg == 3'd4) seg_code[7] = 1'b1;
    if (!valid_reg) seg_code = 8'h00;
  end

  // Registered pin drivers with polarity applied here only
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      digit_sel_reg <= SEG_ACT_LO ? 6'b111110 : 6'b000001;
      seg_reg       <= SEG_ACT_LO ? 8'hFF : 8'h00;
    end else begin
      digit_sel_reg <= SEG_ACT_LO ? ~onehot : onehot;
      seg_reg       <= SEG_ACT_LO ? ~seg_code : seg_code;
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign bcd_out   = bcd_reg;
  assign digit_sel = digit_sel_reg;
  assign seg       = seg_reg;
endmodule

// File: tb/tb_clock_display_scan.sv
// Directed bench for clock_display_scan: conversions, range clamping,
// queued loads, scan timing, polarity and asynchronous reset abort.
module tb_clock_display_scan;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [17:0] data = '0;
  logic        load = 1'b0;
  logic        busy, done, busy_lo, done_lo;
  logic [23:0] bcd_out, bcd_lo;
  logic [5:0]  digit_sel, dsel_lo;
  logic [7:0]  seg, seg_lo;

  int errors = 0;
  int checks = 0;
  logic [23:0] last_bcd = '0;

  always #5 clk = ~clk;

  clock_display_scan #(.SCAN_DIV(4), .SEG_ACT_LO(1'b0)) dut (
    .clk(clk), .resetn(resetn), .data(data), .load(load),
    .busy(busy), .done(done), .bcd_out(bcd_out),
    .digit_sel(digit_sel), .seg(seg)
  );

  clock_display_scan #(.SCAN_DIV(4), .SEG_ACT_LO(1'b1)) dut_lo (
    .clk(clk), .resetn(resetn), .data(data), .load(load),
    .busy(busy_lo), .done(done_lo), .bcd_out(bcd_lo),
    .digit_sel(dsel_lo), .seg(seg_lo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Load d, scramble data during conversion, verify busy window and commit
  task automatic convert(input string tag, input logic [17:0] d, input logic [23:0] exp);
    int bad;
    bad = 0;
    data = d; load = 1'b1;
    tick();                                   // edge k
    load = 1'b0; data = ~d;
    chk({tag, "_busy_k"}, 32'(busy), 32'd1);
    for (int n = 1; n < 18; n++) begin
      tick();
      if (busy !== 1'b1 || done !== 1'b0 || bcd_out !== last_bcd) bad++;
    end
    chk({tag, "_hold"}, bad, 0);
    tick();                                   // edge k+18
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_bcd"}, 32'(bcd_out), 32'(exp));
    last_bcd = exp;
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    $display("conv %s data=%05h bcd=%06h", tag, d, bcd_out);
  endtask

  // Wait for digit i to be scanned, then check both polarities
  task automatic check_digit(input string tag, input int i, input logic [7:0] exp);
    int guard;
    logic [5:0] sel, sel_n;
    logic [7:0] exp_n;
    guard = 0;
    sel   = 6'b000001 << i;
    sel_n = ~sel;
    exp_n = ~exp;
    while (digit_sel !== sel && guard < 40) begin
      tick();
      guard++;
    end
    chk({tag, "_found"}, 32'(guard < 40), 32'd1);
    chk({tag, "_seg"}, 32'(seg), 32'(exp));
    chk({tag, "_seg_lo"}, 32'(seg_lo), 32'(exp_n));
    chk({tag, "_dsel_lo"}, 32'(dsel_lo), 32'(sel_n));
    $display("digit %s idx=%0d seg=%02h", tag, i, seg);
  endtask

  initial begin
    int bad, cnt, guard;
    logic [5:0] start_sel;

    // Reset state
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    chk("rst_seg", 32'(seg), 32'h00);
    chk("rst_dsel", 32'(digit_sel), 32'h01);
    chk("rst_seg_lo", 32'(seg_lo), 32'hFF);
    chk("rst_dsel_lo", 32'(dsel_lo), 32'h3E);
    resetn = 1'b1;
    tick();
    check_digit("blank3", 3, 8'h00);

    // Basic conversions, data scrambled during CONV
    convert("h15", {6'd15, 6'd0, 6'd0}, 24'h150000);
    convert("max", {6'd23, 6'd59, 6'd59}, 24'h235959);
    convert("zero", {6'd0, 6'd0, 6'd0}, 24'h000000);

    // Out-of-range fields become dashes
    convert("range", {6'd24, 6'd60, 6'd5}, 24'hFFFF05);
    tick(); tick();
    check_digit("rng0", 0, 8'h6D);
    check_digit("rng1", 1, 8'h3F);
    check_digit("rng2", 2, 8'hC0);
    check_digit("rng3", 3, 8'h40);
    check_digit("rng4", 4, 8'hC0);
    check_digit("rng5", 5, 8'h40);

    // Loads during CONV queue one follow-up conversion using data at commit
    bad = 0;
    data = {6'd10, 6'd20, 6'd30}; load = 1'b1;
    tick();                                   // edge k
    load = 1'b0; data = {6'd1, 6'd2, 6'd3};
    for (int n = 1; n < 18; n++) begin
      tick();
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      load = (n == 4 || n == 6);
    end
    load = 1'b0;
    tick();                                   // edge k+18
    chk("pend_done1", 32'(done), 32'd1);
    chk("pend_busy1", 32'(busy), 32'd1);
    chk("pend_bcd1", 32'(bcd_out), 32'h102030);
    for (int n = 19; n < 36; n++) begin
      tick();
      if (busy !== 1'b1 || done !== 1'b0 || bcd_out !== 24'h102030) bad++;
    end
    chk("pend_hold", bad, 0);
    tick();                                   // edge k+36
    chk("pend_done2", 32'(done), 32'd1);
    chk("pend_busy2", 32'(busy), 32'd0);
    chk("pend_bcd2", 32'(bcd_out), 32'h010203);
    tick();
    chk("pend_collapse_busy", 32'(busy), 32'd0);
    chk("pend_collapse_done", 32'(done), 32'd0);
    last_bcd = 24'h010203;
    $display("conv pending bcd=%06h", bcd_out);

    // Scan timing and segment codes
    convert("scan", {6'd12, 6'd34, 6'd56}, 24'h123456);
    tick(); tick();
    guard = 0;
    start_sel = digit_sel;
    while (digit_sel === start_sel && guard < 10) begin tick(); guard++; end
    start_sel = digit_sel;
    cnt = 0;
    while (digit_sel === start_sel && cnt < 10) begin tick(); cnt++; end
    chk("scan_step", cnt, 4);
    while (digit_sel !== start_sel && cnt < 50) begin tick(); cnt++; end
    chk("scan_wrap", cnt, 24);
    check_digit("scn0", 0, 8'h7D);
    check_digit("scn1", 1, 8'h6D);
    check_digit("scn2", 2, 8'hE6);
    check_digit("scn3", 3, 8'h4F);
    check_digit("scn4", 4, 8'hDB);
    check_digit("scn5", 5, 8'h06);

    // Asynchronous reset mid-conversion aborts without DONE
    data = {6'd5, 6'd5, 6'd5}; load = 1'b1;
    tick();
    load = 1'b0;
    for (int n = 0; n < 8; n++) tick();
    #2 resetn = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_bcd", 32'(bcd_out), 32'd0);
    chk("arst_seg", 32'(seg), 32'h00);
    chk("arst_dsel", 32'(digit_sel), 32'h01);
    chk("arst_seg_lo", 32'(seg_lo), 32'hFF);
    chk("arst_dsel_lo", 32'(dsel_lo), 32'h3E);
    chk("arst_lo_state", 32'({busy_lo, done_lo, bcd_lo}), 32'd0);
    tick();
    resetn = 1'b1;
    cnt = 0;
    for (int n = 0; n < 25; n++) begin
      tick();
      if (done === 1'b1) cnt++;
    end
    chk("arst_no_done", cnt, 0);
    chk("arst_bcd_after", 32'(bcd_out), 32'd0);
    $display("reset abort done_pulses=%0d", cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
